// File: rtl/eth_frame_arbiter_if.sv
// Ingress/egress bundle for the frame arbiter.
// The arbiter attaches to the slave modport; the traffic environment attaches to master.
interface eth_frame_arbiter_if #(
  parameter int N_PORTS = 4
);
  localparam int SRC_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [8*N_PORTS-1:0] in_data;
  logic [N_PORTS-1:0]   in_valid;
  logic [N_PORTS-1:0]   in_last;
  logic [N_PORTS-1:0]   in_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic [SRC_W-1:0]     out_src;
  logic                 out_trunc;
  logic                 out_runt;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_src, out_trunc, out_runt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_src, out_trunc, out_runt
  );
endinterface

// File: rtl/eth_frame_arbiter.sv
// Frame-granular N:1 byte-stream arbiter with max-size truncation, runt flagging and inter-frame gap.
// Optional ETH_ARB_STRICT_PRIO_EN: lowest-index requester wins instead of round-robin.
module eth_frame_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_BYTES  = 1526,
  parameter int MIN_BYTES  = 64,
  parameter int CNT_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_frame_arbiter_if.slave   bus
);
  localparam int SRC_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;
  localparam state_t AFTER_FRAME = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t             state;
  logic [SRC_W-1:0]   grant;
  logic [CNT_W-1:0]   cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [SRC_W-1:0]   winner;
  logic [7:0]         g_data;
  logic               g_valid;
  logic               g_last;
  logic               xfer_vld;
  logic               beat;
  logic               at_max;
  logic [N_PORTS-1:0] rdy;

`ifdef ETH_ARB_STRICT_PRIO_EN
  function automatic logic [SRC_W-1:0] pick_low(input logic [N_PORTS-1:0] req);
    logic [SRC_W-1:0] sel;
    sel = '0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      if (req[i]) sel = SRC_W'(i);
    end
    return sel;
  endfunction

  always_comb winner = pick_low(bus.in_valid);
`else
  logic [SRC_W-1:0] rr_ptr;

  // Lowest requester above the last winner, else wrap to the lowest requester overall.
  function automatic logic [SRC_W-1:0] pick_rr(input logic [N_PORTS-1:0] req,
                                               input logic [SRC_W-1:0]   ptr);
    logic [SRC_W-1:0] above;
    logic [SRC_W-1:0] lowest;
    logic             hit_above;
    above     = '0;
    lowest    = '0;
    hit_above = 1'b0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      if (req[i]) begin
        lowest = SRC_W'(i);
        if (SRC_W'(i) > ptr) begin
          above     = SRC_W'(i);
          hit_above = 1'b1;
        end
      end
    end
    return hit_above ? above : lowest;
  endfunction

  always_comb winner = pick_rr(bus.in_valid, rr_ptr);
`endif

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant == SRC_W'(i)) begin
        g_data  = bus.in_data[8*i +: 8];
        g_valid = bus.in_valid[i];
        g_last  = bus.in_last[i];
      end
    end
  end

  // DRAIN swallows the tail of a truncated frame, so the source sees ready regardless of egress.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant == SRC_W'(i)) begin
        if (state == XFER)       rdy[i] = bus.out_ready;
        else if (state == DRAIN) rdy[i] = 1'b1;
      end
    end
  end

  assign at_max   = (cnt == CNT_W'(MAX_BYTES-1));
  assign xfer_vld = (state == XFER) && g_valid;
  assign beat     = xfer_vld && bus.out_ready;

  assign bus.in_ready  = rdy;
  assign bus.out_data  = xfer_vld ? g_data : 8'h00;
  assign bus.out_valid = xfer_vld;
  assign bus.out_last  = xfer_vld && (g_last || at_max);
  assign bus.out_trunc = xfer_vld && at_max && !g_last;
  assign bus.out_runt  = xfer_vld && g_last && (cnt < CNT_W'(MIN_BYTES-1));
  assign bus.out_src   = grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
`ifndef ETH_ARB_STRICT_PRIO_EN
      rr_ptr  <= SRC_W'(N_PORTS-1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.in_valid) begin
            grant  <= winner;
`ifndef ETH_ARB_STRICT_PRIO_EN
            rr_ptr <= winner;
`endif
            cnt    <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            if (g_last) begin
              cnt     <= '0;
              gap_cnt <= '0;
              state   <= AFTER_FRAME;
            end else if (at_max) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (g_valid && g_last) begin
            gap_cnt <= '0;
            state   <= AFTER_FRAME;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(IFG_CYCLES-1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_frame_arbiter.sv
// Randomised bench for eth_frame_arbiter: per-port frame sources, an egress monitor,
// and a frame-level reference model (arbitration order, truncation, runt, gap timing).
module tb_eth_frame_arbiter;
  localparam int N    = 4;
  localparam int IFG  = 12;
  localparam int MAXB = 1526;
  localparam int MINB = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_frame_arbiter_if #(.N_PORTS(N)) bus ();

  eth_frame_arbiter #(
    .N_PORTS(N), .IFG_CYCLES(IFG), .MAX_BYTES(MAXB), .MIN_BYTES(MINB), .CNT_W(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int  src;
    int  start;
    int  len;
    bit  trunc;
    bit  runt;
    bit  bad;
    int  first;
    int  last;
  } obs_t;

  int checks = 0;
  int failures = 0;
  int seed;
  int cyc = 0;
  int next_id = 0;
  int mptr = N-1;

  int q_len [N][$];
  int q_id  [N][$];
  int pos [N];
  int accepted [N];
  bit jitter = 1'b0;
  bit rdy_rand = 1'b0;
  bit flush_req = 1'b0;
  int mirror_err = 0;
  int flag_err = 0;

  obs_t       obs_f[$];
  logic [7:0] obs_b[$];
  obs_t       cur;
  bit         in_frame = 1'b0;
  logic [N-1:0] fire;
  logic [N-1:0] exp_rdy;

  int exp_port[$];
  int exp_id[$];
  int exp_len[$];

  function automatic logic [7:0] byte_of(int p, int id, int i);
    return 8'((p*59 + id*17 + i*7 + (i >> 5) + seed) & 255);
  endfunction

  // Source drivers and egress monitor: sample at negedge, update inputs just after posedge.
  initial begin
    for (int p = 0; p < N; p++) begin pos[p] = 0; accepted[p] = 0; end
    bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      fire = bus.in_valid & bus.in_ready;
      if (bus.out_valid) begin
        exp_rdy = '0;
        exp_rdy[bus.out_src] = bus.out_ready;
        if (bus.in_ready !== exp_rdy) mirror_err++;
      end else if (bus.out_last || bus.out_trunc || bus.out_runt) begin
        flag_err++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur.src = int'(bus.out_src); cur.start = obs_b.size(); cur.len = 0;
          cur.bad = 1'b0; cur.first = cyc; cur.trunc = 1'b0; cur.runt = 1'b0;
        end
        if (int'(bus.out_src) != cur.src) cur.bad = 1'b1;
        obs_b.push_back(bus.out_data);
        cur.len++;
        if (bus.out_last) begin
          cur.trunc = bus.out_trunc; cur.runt = bus.out_runt; cur.last = cyc;
          obs_f.push_back(cur);
          in_frame = 1'b0;
        end else if (bus.out_trunc || bus.out_runt) begin
          cur.bad = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (flush_req) begin
        for (int p = 0; p < N; p++) begin q_len[p].delete(); q_id[p].delete(); pos[p] = 0; end
        obs_f.delete(); obs_b.delete(); in_frame = 1'b0;
        flush_req = 1'b0;
      end else begin
        for (int p = 0; p < N; p++) begin
          if (fire[p] && q_len[p].size() > 0) begin
            accepted[p]++;
            pos[p]++;
            if (pos[p] >= q_len[p][0]) begin
              void'(q_len[p].pop_front()); void'(q_id[p].pop_front()); pos[p] = 0;
            end
          end
        end
      end
      for (int p = 0; p < N; p++) begin
        if (q_len[p].size() > 0) begin
          bus.in_data[8*p +: 8] = byte_of(p, q_id[p][0], pos[p]);
          bus.in_last[p]  = (pos[p] == q_len[p][0]-1);
          bus.in_valid[p] = !(jitter && pos[p] > 0 && $urandom_range(0, 3) == 0);
        end else begin
          bus.in_data[8*p +: 8] = 8'h00; bus.in_last[p] = 1'b0; bus.in_valid[p] = 1'b0;
        end
      end
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic enq(int p, int len);
    q_len[p].push_back(len);
    q_id[p].push_back(next_id);
    next_id++;
  endtask

  // Frame-level model: every port holding a frame requests at arbitration time.
  task automatic build_expected();
    int taken [N];
    int total;
    int w;
    exp_port.delete(); exp_id.delete(); exp_len.delete();
    total = 0;
    for (int p = 0; p < N; p++) begin taken[p] = 0; total += q_len[p].size(); end
    for (int k = 0; k < total; k++) begin
      w = -1;
`ifdef ETH_ARB_STRICT_PRIO_EN
      for (int p = 0; p < N; p++)
        if (w < 0 && taken[p] < q_len[p].size()) w = p;
`else
      for (int j = 1; j <= N; j++) begin
        int p;
        p = (mptr + j) % N;
        if (w < 0 && taken[p] < q_len[p].size()) w = p;
      end
`endif
      exp_port.push_back(w);
      exp_len.push_back(q_len[w][taken[w]]);
      exp_id.push_back(q_id[w][taken[w]]);
      taken[w]++;
      mptr = w;
    end
  endtask

  function automatic bit src_empty();
    for (int p = 0; p < N; p++) if (q_len[p].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(string name, int budget);
    int c;
    c = 0;
    while ((obs_f.size() < exp_port.size() || !src_empty()) && c < budget) begin
      @(negedge clk); c++;
    end
    repeat (IFG + 4) @(negedge clk);
    checks++;
    if (c >= budget) begin
      failures++;
      $display("FAIL %s timeout: frames seen %0d, required %0d", name, obs_f.size(), exp_port.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush_req = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mptr = N-1;
    @(negedge clk);
  endtask

  task automatic check_frames(string name, bit exact_gap);
    int n;
    checks++;
    if (obs_f.size() !== exp_port.size()) begin
      failures++;
      $display("FAIL %s frame_count: got %0d, expected %0d", name, obs_f.size(), exp_port.size());
    end
    n = (obs_f.size() < exp_port.size()) ? obs_f.size() : exp_port.size();
    for (int k = 0; k < n; k++) begin
      obs_t f;
      int el, lim, want_gap;
      bit ok;
      f = obs_f[k];
      el = (exp_len[k] > MAXB) ? MAXB : exp_len[k];
      checks++;
      if (f.src !== exp_port[k]) begin
        failures++; $display("FAIL %s[%0d] src: got %0d, expected %0d", name, k, f.src, exp_port[k]);
      end
      checks++;
      if (f.len !== el) begin
        failures++; $display("FAIL %s[%0d] length: got %0d, expected %0d", name, k, f.len, el);
      end
      checks++;
      if (f.trunc !== (exp_len[k] > MAXB)) begin
        failures++; $display("FAIL %s[%0d] trunc: got %0b, expected %0b", name, k, f.trunc, exp_len[k] > MAXB);
      end
      checks++;
      if (f.runt !== (exp_len[k] < MINB)) begin
        failures++; $display("FAIL %s[%0d] runt: got %0b, expected %0b", name, k, f.runt, exp_len[k] < MINB);
      end
      ok = 1'b1;
      lim = (f.len < el) ? f.len : el;
      for (int i = 0; i < lim; i++)
        if (obs_b[f.start + i] !== byte_of(exp_port[k], exp_id[k], i)) ok = 1'b0;
      checks++;
      if (!ok || f.bad) begin
        failures++; $display("FAIL %s[%0d] payload/src_stability: data_ok=%0b unstable=%0b, expected 1/0", name, k, ok, f.bad);
      end
      // Gap after a frame: drained tail, IFG_CYCLES of GAP, one IDLE arbitration cycle.
      if (exact_gap && k > 0) begin
        want_gap = ((exp_len[k-1] > MAXB) ? exp_len[k-1] - MAXB : 0) + IFG + 2;
        checks++;
        if (f.first - obs_f[k-1].last !== want_gap) begin
          failures++; $display("FAIL %s[%0d] gap: got %0d cycles, expected %0d", name, k, f.first - obs_f[k-1].last, want_gap);
        end
      end
    end
    obs_f.delete(); obs_b.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; flush_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_trunc, bus.out_runt} !== 4'b0000) begin
      failures++; $display("FAIL reset flags: got %b, expected 0000", {bus.out_valid, bus.out_last, bus.out_trunc, bus.out_runt});
    end
    checks++;
    if (bus.out_src !== '0) begin
      failures++; $display("FAIL reset out_src: got %0d, expected 0", bus.out_src);
    end
    checks++;
    if (bus.in_ready !== '0 || bus.out_data !== 8'h00) begin
      failures++; $display("FAIL reset ready/data: got %b/%h, expected 0/00", bus.in_ready, bus.out_data);
    end
    rst_n = 1'b1; mptr = N-1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset idle_valid: got %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_single();
    jitter = 1'b0; rdy_rand = 1'b0;
    enq(1, 64);
    build_expected();
    wait_done("single", 500);
    check_frames("single", 1'b1);
  endtask

  task automatic test_round_robin();
    do_reset();
    jitter = 1'b0; rdy_rand = 1'b0;
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) enq(p, 64);
    build_expected();
    wait_done("round_robin", 2000);
    check_frames("round_robin", 1'b1);
  endtask

  task automatic test_truncate();
    jitter = 1'b0; rdy_rand = 1'b0;
    accepted[2] = 0;
    enq(2, 2000);
    enq(3, 64);
    build_expected();
    wait_done("truncate", 4000);
    checks++;
    if (accepted[2] !== 2000) begin
      failures++; $display("FAIL truncate drained_bytes: got %0d accepted, expected 2000", accepted[2]);
    end
    check_frames("truncate", 1'b1);
  endtask

  task automatic test_runt();
    jitter = 1'b0; rdy_rand = 1'b0;
    enq(0, 40); enq(0, 63); enq(0, 64); enq(0, 65); enq(0, 1);
    build_expected();
    wait_done("runt", 2000);
    check_frames("runt", 1'b1);
  endtask

  task automatic test_backpressure();
    jitter = 1'b1; rdy_rand = 1'b1;
    mirror_err = 0; flag_err = 0;
    for (int k = 0; k < 12; k++) enq($urandom_range(0, N-1), $urandom_range(1, 200));
    build_expected();
    wait_done("backpressure", 20000);
    check_frames("backpressure", 1'b0);
    checks++;
    if (mirror_err !== 0) begin
      failures++; $display("FAIL backpressure in_ready_mirror: got %0d bad cycles, expected 0", mirror_err);
    end
    checks++;
    if (flag_err !== 0) begin
      failures++; $display("FAIL backpressure idle_flags: got %0d bad cycles, expected 0", flag_err);
    end
    jitter = 1'b0; rdy_rand = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int c;
    jitter = 1'b0; rdy_rand = 1'b0;
    enq(0, 100);
    build_expected();
    c = 0;
    while (!(in_frame && cur.len >= 10) && c < 300) begin @(negedge clk); c++; end
    checks++;
    if (c >= 300) begin
      failures++; $display("FAIL reset_mid start: got no frame in flight, expected beat 10");
    end
    rst_n = 1'b0; flush_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_trunc, bus.out_runt, bus.in_ready} !== '0) begin
      failures++; $display("FAIL reset_mid outputs: got %b, expected all 0",
                           {bus.out_valid, bus.out_last, bus.out_trunc, bus.out_runt, bus.in_ready});
    end
    rst_n = 1'b1; mptr = N-1;
    @(negedge clk);
    // Without the reset the pointer would sit on port 0 and favour port 1.
    enq(1, 64); enq(0, 70);
    build_expected();
    wait_done("reset_mid", 1000);
    check_frames("reset_mid", 1'b1);
  endtask

  initial begin
    seed = int'($urandom_range(0, 255));
    test_reset();
    test_single();
    test_round_robin();
    test_truncate();
    test_runt();
    test_backpressure();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
